// File: rtl/rip_const_pkg.sv
// rip_const: shared constants and enums for the rip memory subsystem
package rip_const;
  localparam int B_WIDTH = 8;
  typedef enum logic [3:0] {
    LB  = 4'h0,
    LH  = 4'h1,
    LW  = 4'h2,
    LBU = 4'h4,
    LHU = 4'h5,
    SB  = 4'h8,
    SH  = 4'h9,
    SW  = 4'ha
  } mem_funct3_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/rip_load_store_unit_align.sv
// rip_lsu_align: sub-word strobe/lane/extend logic and op legality decode
module rip_lsu_align
  import rip_const::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                           load,
  input  logic                           store,
  input  logic [2:0]                     funct3,
  input  logic [1:0]                     off,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH/B_WIDTH-1:0]  we,
  output logic [DATA_WIDTH-1:0]          din,
  output logic                           misaligned,
  output logic                           illegal,
  input  logic [2:0]                     ld_funct3,
  input  logic [1:0]                     ld_off,
  input  logic [DATA_WIDTH-1:0]          dout,
  output logic [DATA_WIDTH-1:0]          rdata
);
  logic [3:0] st;
  logic [3:0] ld;
  logic [DATA_WIDTH-1:0] sh;
  // decode the incoming op and format the returning load word
  always_comb begin
    st = {store, funct3};
    ld = {1'b0, ld_funct3};
    illegal = (load == store) || (load && (funct3 == 3'd3 || funct3[2:1] == 2'b11)) || (store && funct3 > 3'd2);
    misaligned = !illegal && ((funct3[1:0] == 2'd2 && off != 2'd0) || (funct3[1:0] == 2'd1 && off[0]));
    we = st == SW ? 4'b1111 : st == SH ? 4'b0011 << off : st == SB ? 4'b0001 << off : 4'b0000;
    din = st == SB ? {4{wdata[7:0]}} : st == SH ? {2{wdata[15:0]}} : wdata;
    sh = dout >> {ld_off, 3'b000};
    rdata = ld == LB  ? {{24{sh[7]}}, sh[7:0]} :
            ld == LH  ? {{16{sh[15]}}, sh[15:0]} :
            ld == LBU ? {24'b0, sh[7:0]} :
            ld == LHU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/rip_load_store_unit.sv
// rip_load_store_unit: turns core load/store micro-ops into single MMU channel-1 transactions
module rip_load_store_unit
  import rip_const::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_load,
  input  logic                           req_store,
  input  logic [2:0]                     req_funct3,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           resp_misaligned,
  output logic                           resp_illegal,
  output logic [DATA_WIDTH/B_WIDTH-1:0]  mem_we,
  output logic                           mem_re,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_din,
  input  logic [DATA_WIDTH-1:0]          mem_dout,
  input  logic                           mem_busy
);
  localparam int NB = DATA_WIDTH / B_WIDTH;
  lsu_state_t state, state_nxt;
  logic [2:0] op_funct3;
  logic [1:0] op_off;
  logic [NB-1:0] al_we;
  logic [DATA_WIDTH-1:0] al_din, al_rdata;
  logic al_mis, al_ill, accept;
  assign accept = req_valid && req_ready;
  rip_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .load(req_load), .store(req_store), .funct3(req_funct3), .off(req_addr[1:0]), .wdata(req_wdata),
    .we(al_we), .din(al_din), .misaligned(al_mis), .illegal(al_ill),
    .ld_funct3(op_funct3), .ld_off(op_off), .dout(mem_dout), .rdata(al_rdata)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // next state: errors skip memory, busy only matters once in WAIT
  always_comb begin
    state_nxt = state == IDLE  ? (accept ? ((al_mis || al_ill) ? RESP : ISSUE) : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? (mem_busy ? WAIT : RESP) : IDLE;
  end
  // registered outputs and captured op fields
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal <= 1'b0;
      mem_we <= '0;
      mem_re <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      op_funct3 <= '0;
      op_off <= '0;
    end else begin
      req_ready <= state_nxt == IDLE;
      resp_valid <= state_nxt == RESP;
      if (accept) begin
        op_funct3 <= req_funct3;
        op_off <= req_addr[1:0];
        if (al_mis || al_ill) begin
          resp_rdata <= '0;
          resp_misaligned <= al_mis;
          resp_illegal <= al_ill;
        end else begin
          mem_re <= req_load;
          mem_we <= req_store ? al_we : '0;
          mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_din <= al_din;
        end
      end
      if (state == WAIT && !mem_busy) begin
        mem_re <= 1'b0;
        mem_we <= '0;
        resp_rdata <= mem_re ? al_rdata : '0;
        resp_misaligned <= 1'b0;
        resp_illegal <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rip_load_store_unit.sv
// tb_rip_load_store_unit: scoreboard bench with byte-level reference memory and a busy-stretching MMU model
module tb_rip_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_misaligned, resp_illegal, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0] mem_we;
  logic mem_busy = 1'b0;

  typedef struct {
    int acc;
    logic err, mis, ill, re, chk_din;
    logic [3:0] we;
    logic [31:0] addr, din, rdata;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit pending = 0, bad = 0, ready_chk = 0, active = 0;
  int cyc = 0, busy_cnt = 0, busy_len = 0, rem = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mmu_mem [16];
  logic [7:0] ref_mem [64];
  logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 clk = ~clk;

  rip_load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  assign mem_dout = mmu_mem[mem_addr[5:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // MMU model: write on first sight of a request, then hold busy for busy_len cycles
  always @(negedge clk) begin
    if (mem_re || mem_we != 4'b0) begin
      if (!active) begin
        active = 1;
        rem = busy_len;
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mmu_mem[mem_addr[5:2]][8*b +: 8] = mem_din[8*b +: 8];
      end else if (rem > 0) rem--;
      mem_busy = rem > 0;
    end else begin
      active = 0;
      mem_busy = 1'b0;
    end
  end

  // monitor: samples just after each edge, pops expectations at their accept edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pending = 0;
      ready_chk = 0;
      q.delete();
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_resp", {29'b0, resp_valid, resp_misaligned, resp_illegal}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_req", {27'b0, mem_re, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
    end else begin
      if (ready_chk) begin
        chk("ready_after_resp", 32'(req_ready), 1);
        ready_chk = 0;
      end
      if (!pending && q.size() > 0 && q[0].acc == cyc) begin
        cur = q.pop_front();
        pending = 1;
        busy_cnt = 0;
        bad = 0;
      end
      if (pending) begin
        if (cyc >= cur.acc + 2 && mem_busy) busy_cnt++;
        if (resp_valid) begin
          chk("rdata", resp_rdata, cur.rdata);
          chk("flags", {30'b0, resp_misaligned, resp_illegal}, {30'b0, cur.mis, cur.ill});
          chk("latency", 32'(cyc - cur.acc), cur.err ? 0 : 32'(2 + busy_cnt));
          chk("mem_req_stable", 32'(bad), 0);
          chk("mem_idle_at_resp", {27'b0, mem_re, mem_we}, 0);
          chk("ready_in_resp", 32'(req_ready), 0);
          pending = 0;
          ready_chk = 1;
        end else begin
          if (mem_re !== cur.re || mem_we !== cur.we || mem_addr !== cur.addr ||
              (cur.chk_din && mem_din !== cur.din) || req_ready) bad = 1;
          if (cyc - cur.acc > 40) begin
            chk("resp_timeout", 32'(cyc - cur.acc), 0);
            pending = 0;
          end
        end
      end else begin
        if (resp_valid) chk("spurious_resp", 32'(resp_valid), 0);
        if (mem_re || mem_we != 4'b0) chk("idle_mem_req", {27'b0, mem_re, mem_we}, 0);
      end
    end
  end

  // reference model works on bytes; pushes the expected transaction at its accept edge
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int bl);
    exp_t e;
    int a, sz, tmo;
    logic [31:0] v;
    e = '{default: '0};
    a = int'(addr[5:0]);
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    e.ill = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2);
    e.mis = !e.ill && (a % sz != 0);
    e.err = e.ill || e.mis;
    if (!e.err) begin
      e.addr = addr & ~32'd3;
      e.re = ld;
      if (st) begin
        e.chk_din = 1;
        e.din = sz == 1 ? {4{wd[7:0]}} : sz == 2 ? {2{wd[15:0]}} : wd;
        for (int k = 0; k < sz; k++) begin
          ref_mem[a + k] = wd[8*k +: 8];
          e.we[(a + k) % 4] = 1'b1;
        end
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | (32'hffffffff << (8 * sz));
        e.rdata = v;
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_load = ld;
    req_store = st;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    tmo = 0;
    while (!req_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(tmo), 0);
    end else begin
      busy_len = bl;
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr = $urandom;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200 && (q.size() != 0 || pending || !req_ready); i++) @(negedge clk);
    if (i == 200) chk("idle_timeout", 32'(i), 0);
  endtask

  initial begin
    bit ld, st;
    int sel, a;
    logic [2:0] f3;
    logic [31:0] ad;
    for (int i = 0; i < 16; i++) begin
      mmu_mem[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = mmu_mem[i][8*k +: 8];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(0, 1, 3'd2, 32'h4, 32'h89abcdef, 0);
    issue(1, 0, 3'd2, 32'h4, 32'h0, 1);
    issue(0, 1, 3'd0, 32'h7, 32'h1234565a, 0);
    issue(1, 0, 3'd0, 32'h7, 32'h0, 2);
    issue(0, 1, 3'd0, 32'h7, 32'habcdeff0, 0);
    issue(1, 0, 3'd0, 32'h7, 32'h0, 0);
    issue(1, 0, 3'd4, 32'h7, 32'h0, 0);
    issue(0, 1, 3'd1, 32'h6, 32'h55558001, 3);
    issue(1, 0, 3'd1, 32'h6, 32'h0, 0);
    issue(1, 0, 3'd5, 32'h6, 32'h0, 0);
    issue(1, 0, 3'd2, 32'h2, 32'h0, 0);
    issue(0, 1, 3'd1, 32'h5, 32'hffffffff, 0);
    issue(1, 0, 3'd3, 32'h0, 32'h0, 0);
    issue(1, 1, 3'd2, 32'h0, 32'h0, 0);
    issue(0, 1, 3'd3, 32'h0, 32'h0, 0);
    issue(0, 1, 3'd2, 32'h8, 32'hcafef00d, 10);
    issue(1, 0, 3'd2, 32'h8, 32'h0, 10);
    wait_idle();
    issue(1, 0, 3'd2, 32'hc, 32'h0, 10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1, 3'd2, 32'h10, 32'h13579bdf, 1);
    issue(1, 0, 3'd2, 32'h10, 32'h0, 0);
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 19);
      ld = sel == 0 ? 1'b0 : sel == 1 ? 1'b1 : sel[0];
      st = sel == 0 ? 1'b0 : sel == 1 ? 1'b1 : !sel[0];
      f3 = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) :
           ld ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = a & ~3;
      ad = {$urandom, 6'b0} | 32'(a);
      issue(ld, st, f3, ad, $urandom, $urandom_range(0, 3));
    end
    wait_idle();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rip_load_store_unit.md
Name: rip_load_store_unit

Overview:
- Upstream neighbour of rip_memory_management_unit. It converts core load/store micro-ops into channel-1 requests (we_1/re_1/addr_1/din_1, completion on busy_1).
- Performs RV32 sub-word alignment: byte-strobe generation, store-data lane replication, load-data shifting, and sign/zero extension.
- Detects misaligned and illegal accesses before they reach memory.
- Handles one outstanding request at a time.

Parameters:
- ADDR_WIDTH, 32, address width; must equal the MMU ADDR_WIDTH.
- DATA_WIDTH, 32, data width; fixed at 32 (RV32); strobe width is DATA_WIDTH/B_WIDTH = 4.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  core presents an op.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_load  in  1  op is a load.
- req_store  in  1  op is a store.
- req_funct3  in  3  RV funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors; held until the next resp_valid.
- resp_misaligned  out  1  qualifies resp_valid.
- resp_illegal  out  1  qualifies resp_valid.
- mem_we  out  DATA_WIDTH/B_WIDTH  drives MMU we_1.
- mem_re  out  1  drives MMU re_1.
- mem_addr  out  ADDR_WIDTH  drives MMU addr_1; word-aligned (addr[1:0] forced to 0).
- mem_din  out  DATA_WIDTH  drives MMU din_1.
- mem_dout  in  DATA_WIDTH  MMU dout_1.
- mem_busy  in  1  MMU busy_1.

Behaviour:
- Reset values: all outputs are 0 except req_ready=1; state=IDLE.
- State machine:
  - States are IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - A request is accepted on the edge where req_valid && req_ready. Op fields are captured at that edge.
  - Illegal op: req_load==req_store, load funct3 in {3,6,7}, or store funct3 >2. Goes to RESP with resp_illegal=1; no memory access.
  - Misaligned op: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0. Goes to RESP with resp_misaligned=1; no memory access.
  - Illegal takes priority over misaligned.
  - Otherwise goes to ISSUE with mem_re or mem_we, mem_addr and mem_din driven.
- ISSUE:
  - Lasts one cycle, with the request held.
  - mem_busy is ignored in this cycle (the MMU raises busy one cycle after request).
  - Next state is WAIT.
- WAIT:
  - The request is held unchanged while mem_busy=1.
  - On the edge where mem_busy=0: clear mem_re/mem_we to 0, capture the formatted mem_dout for loads, then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Error flags are 0 on normal completion.
- Latency:
  - Error ops: resp_valid 1 cycle after accept.
  - Memory ops: minimum 3 cycles after accept (accept, ISSUE, WAIT with busy low); otherwise 3 cycles plus the busy cycles.
- Store formatting (off = addr[1:0]):
  - SB: mem_we = 4'b0001<<off, mem_din = {4{wdata[7:0]}}.
  - SH: mem_we = 4'b0011<<off, mem_din = {2{wdata[15:0]}}.
  - SW: mem_we = 4'b1111, mem_din = wdata.
- Load formatting:
  - Shift mem_dout right by 8*off.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW is passed through.
- mem_re and mem_we are never both nonzero. Both are 0 in IDLE and RESP.
- req_valid while not ready is ignored; the core must hold its request.
- Reset mid-operation returns to IDLE and drops mem_re/mem_we on the same edge, and no resp_valid is issued. The MMU is reset by the same system reset event, so no orphan transaction remains.

Decomposition:
- rip_const (B_WIDTH already defined there) gets new entries:
  - mem_funct3_t enum: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - lsu_state_t enum: IDLE, ISSUE, WAIT, RESP.
- One combinational sub-module, rip_lsu_align, holds the strobe, lane-replication, shift and extend logic plus the misaligned/illegal decode.

Test Plan:
- SW 0x89abcdef @0x4, then LW @0x4 -> mem_we=4'b1111, mem_addr=0x4; load returns resp_rdata=0x89abcdef, resp_valid pulse exactly once.
- SB 0xXXXXXX5a @0x7 -> mem_we=4'b1000, mem_din=0x5a5a5a5a, mem_addr=0x4. Then LB @0x7 -> 0x0000005a; after SB 0xf0 @0x7, LB -> 0xfffffff0 and LBU -> 0x000000f0.
- SH 0x8001 @0x6 -> mem_we=4'b1100. Then LH @0x6 -> 0xffff8001 and LHU @0x6 -> 0x00008001.
- LW @0x2 and SH @0x5 -> resp_misaligned=1 one cycle after accept, with no mem_re/mem_we activity. Load funct3=3 -> resp_illegal=1.
- Bench holds mem_busy high for 10 cycles -> request signals stable throughout; resp_valid 1 cycle after busy falls; req_ready low until the RESP cycle ends.
- Assert rst during WAIT -> next cycle all mem_* and resp_* are 0, req_ready=1; a subsequent SW/LW pair completes correctly.
